// File: rtl/rx_pkg.sv
// Shared types and constants for the RGB565 DE-mode receive capture block.
package rx_pkg;

    localparam int DIM_W = 11;
    localparam int RES_W = 20;
    localparam int TOT_W = 2 * DIM_W;
    localparam logic [DIM_W-1:0] DIM_SAT = 11'd2047;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        VERIFY,
        LOCKED,
        PAD
    } rx_state_t;

    function automatic int burst_len(input int log2);
        return 1 << log2;
    endfunction

    // Pixels still needed to pad a frame of h*v up to the next burst boundary.
    function automatic logic [RES_W-1:0] burst_residue(input logic [DIM_W-1:0] h,
                                                       input logic [DIM_W-1:0] v,
                                                       input int log2);
        logic [TOT_W-1:0] total;
        logic [RES_W-1:0] r;
        total = {{DIM_W{1'b0}}, h} * {{DIM_W{1'b0}}, v};
        r     = RES_W'(total & TOT_W'(burst_len(log2) - 1));
        return (r == '0) ? '0 : RES_W'(burst_len(log2)) - r;
    endfunction

endpackage

// File: rtl/rx_frame_meter.sv
// Per-frame resolution meter: VS/DE edge detection, line and line-count
// measurement, and the line-consistency check that decides frame validity.
module rx_frame_meter
    import rx_pkg::*;
(
    input  logic             lcd_pclk,
    input  logic             rst_n,
    input  logic             de_q,
    input  logic             vs_q,
    output logic             fb,
    output logic             de_rise,
    output logic [DIM_W-1:0] frame_h,
    output logic [DIM_W-1:0] frame_v,
    output logic             frame_valid
);

    logic             de_d;
    logic             vs_d;
    logic             de_fall;
    logic             line_sat;
    logic             bad;
    logic             bad_nxt;
    logic [DIM_W-1:0] hcnt;
    logic [DIM_W-1:0] vcnt;
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] vcnt_nxt;
    logic [DIM_W-1:0] width_nxt;

    assign fb      = vs_q & ~vs_d;
    assign de_rise = de_q & ~de_d;
    assign de_fall = ~de_q & de_d;

    // The *_nxt values fold in a line ending on this very cycle, so an FB
    // coinciding with a DE fall still credits that line to the ending frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        vcnt_nxt  = vcnt;
        width_nxt = width;
        bad_nxt   = bad;
        if (de_fall) begin
            if (vcnt == '0) begin
                width_nxt = hcnt;
            end else if (hcnt != width) begin
                bad_nxt = 1'b1;
            end
            if (line_sat || vcnt == DIM_SAT) begin
                bad_nxt = 1'b1;
            end
            if (vcnt != DIM_SAT) begin
                vcnt_nxt = vcnt + DIM_W'(1);
            end
        end
    end

    // A line still active at FB belongs to the new frame and spoils the old one.
    assign frame_h     = width_nxt;
    assign frame_v     = vcnt_nxt;
    assign frame_valid = !bad_nxt && !de_q && (width_nxt != '0) && (vcnt_nxt != '0);

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_d     <= 1'b0;
            vs_d     <= 1'b0;
            hcnt     <= '0;
            line_sat <= 1'b0;
            vcnt     <= '0;
            width    <= '0;
            bad      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            de_d <= de_q;
            vs_d <= vs_q;
            if (de_q) begin
                if (hcnt == DIM_SAT) begin
                    line_sat <= 1'b1;
                end else begin
                    hcnt <= hcnt + DIM_W'(1);
                end
            end else begin
                hcnt     <= '0;
                line_sat <= 1'b0;
            end
            if (fb) begin
                vcnt  <= '0;
                width <= '0;
                bad   <= 1'b0;
            end else begin
                vcnt  <= vcnt_nxt;
                width <= width_nxt;
                bad   <= bad_nxt;
            end
        end
    end

endmodule

// File: rtl/rgb_rx_capture.sv
// RGB565 DE-mode receive capture: resolution lock FSM, burst residue and write path.
// Optional burst padding after each locked FB is built when RX_BURST_PAD_EN is defined.
module rgb_rx_capture
    import rx_pkg::*;
#(
    parameter int          BURST_LEN_LOG2 = 5,
    parameter bit          SYNC_ACT_HIGH  = 1'b1,
    parameter logic [15:0] PAD_COLOR      = 16'h0000
) (
    input  logic             lcd_pclk,
    input  logic             rst_n,
    input  logic             rx_de,
    input  logic             rx_hs,
    input  logic             rx_vs,
    input  logic [15:0]      rx_rgb,
    output logic             wr_en,
    output logic [15:0]      wr_data,
    output logic             wr_sof,
    output logic [DIM_W-1:0] o_h_disp,
    output logic [DIM_W-1:0] o_v_disp,
    output logic             input_done,
    output logic [RES_W-1:0] fifo_left_s,
    output logic             err_pulse
);

    logic             de_q;
    logic             vs_q;
    logic [15:0]      rgb_q;
    logic             unused_hs;
    logic             fb;
    logic             de_rise;
    logic             frame_valid;
    logic [DIM_W-1:0] frame_h;
    logic [DIM_W-1:0] frame_v;
    logic [DIM_W-1:0] cand_h;
    logic [DIM_W-1:0] cand_v;
    logic [RES_W-1:0] pad_cnt;
    logic             match;
    logic             wr_active;
    logic             wr_active_nxt;
    logic             pad_write;
    logic             cand_load;
    logic             lock_set;
    logic             lock_drop;
    logic             err_set;
    logic             sof_set;
    rx_state_t        state;
    rx_state_t        state_nxt;

    // HS carries no information in DE mode.
    assign unused_hs = rx_hs;

    // VS is stored polarity-normalised so a reset value of 0 never looks like an edge.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_q  <= 1'b0;
            vs_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            de_q  <= rx_de;
            vs_q  <= SYNC_ACT_HIGH ? rx_vs : ~rx_vs;
            rgb_q <= rx_rgb;
        end
    end

    rx_frame_meter u_meter (
        .lcd_pclk    (lcd_pclk),
        .rst_n       (rst_n),
        .de_q        (de_q),
        .vs_q        (vs_q),
        .fb          (fb),
        .de_rise     (de_rise),
        .frame_h     (frame_h),
        .frame_v     (frame_v),
        .frame_valid (frame_valid)
    );

    assign match = frame_valid && (frame_h == cand_h) && (frame_v == cand_v);

    always_comb begin
        state_nxt     = state;
        wr_active_nxt = wr_active;
        cand_load     = 1'b0;
        lock_set      = 1'b0;
        lock_drop     = 1'b0;
        err_set       = 1'b0;
        sof_set       = 1'b0;
        unique case (state)
            IDLE: begin
                if (fb) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (fb) begin
                    if (frame_valid) begin
                        cand_load = 1'b1;
                        state_nxt = VERIFY;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            VERIFY: begin
                if (fb) begin
                    if (match) begin
                        lock_set  = 1'b1;
                        state_nxt = LOCKED;
                    end else if (frame_valid) begin
                        cand_load = 1'b1;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = MEASURE;
                    end
                end
            end
            LOCKED: begin
                if (fb) begin
                    if (match) begin
                        wr_active_nxt = 1'b1;
`ifdef RX_BURST_PAD_EN
                        if (fifo_left_s != '0) state_nxt = PAD;
                        else                   sof_set   = 1'b1;
`else
                        sof_set = 1'b1;
`endif
                    end else begin
                        wr_active_nxt = 1'b0;
                        lock_drop     = 1'b1;
                        err_set       = 1'b1;
                        cand_load     = frame_valid;
                        state_nxt     = frame_valid ? VERIFY : MEASURE;
                    end
                end
            end
            PAD: begin
                // Image data arriving before padding completes means the timing is broken.
                if (de_rise) begin
                    wr_active_nxt = 1'b0;
                    lock_drop     = 1'b1;
                    err_set       = 1'b1;
                    state_nxt     = MEASURE;
                end else if (pad_cnt == '0) begin
                    sof_set   = 1'b1;
                    state_nxt = LOCKED;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pad_write = (state_nxt == PAD);

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_active   <= 1'b0;
            cand_h      <= '0;
            cand_v      <= '0;
            pad_cnt     <= '0;
            o_h_disp    <= '0;
            o_v_disp    <= '0;
            fifo_left_s <= '0;
            input_done  <= 1'b0;
            err_pulse   <= 1'b0;
            wr_sof      <= 1'b0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
        end else begin
            state     <= state_nxt;
            wr_active <= wr_active_nxt;
            err_pulse <= err_set;
            wr_sof    <= sof_set;
            if (cand_load) begin
                cand_h <= frame_h;
                cand_v <= frame_v;
            end
            if (lock_set) begin
                o_h_disp    <= frame_h;
                o_v_disp    <= frame_v;
                fifo_left_s <= burst_residue(frame_h, frame_v, BURST_LEN_LOG2);
                input_done  <= 1'b1;
            end else if (lock_drop) begin
                input_done <= 1'b0;
            end
            if (pad_write) begin
                pad_cnt <= (state == PAD) ? pad_cnt - RES_W'(1) : fifo_left_s - RES_W'(1);
            end
            wr_en   <= pad_write | (de_q & wr_active_nxt);
            wr_data <= pad_write ? PAD_COLOR : rgb_q;
        end
    end

endmodule

// File: tb/tb_rgb_rx_capture.sv
// Self-checking bench for rgb_rx_capture: random pixel data and timing against a frame-level lock model.
module tb_rgb_rx_capture;

    localparam int          BURST     = 32;
    localparam logic [15:0] PAD_COLOR = 16'h0000;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } pix_t;

    logic        lcd_pclk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        rx_de    = 1'b0;
    logic        rx_hs    = 1'b1;
    logic        rx_vs    = 1'b0;
    logic [15:0] rx_rgb   = '0;
    logic        rx_vs_n;

    logic        wr_en, wr_sof, input_done, err_pulse;
    logic [15:0] wr_data;
    logic [10:0] o_h_disp, o_v_disp;
    logic [19:0] fifo_left_s;

    logic        lo_input_done, lo_err_pulse;
    logic [10:0] lo_h_disp, lo_v_disp;
    logic [19:0] lo_fifo_left_s;
    logic        lo_unused_wr_en, lo_unused_wr_sof;
    logic [15:0] lo_unused_wr_data;

    assign rx_vs_n = ~rx_vs;

    rgb_rx_capture #(.BURST_LEN_LOG2(5), .SYNC_ACT_HIGH(1'b1), .PAD_COLOR(PAD_COLOR)) dut (
        .lcd_pclk(lcd_pclk), .rst_n(rst_n), .rx_de(rx_de), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .rx_rgb(rx_rgb), .wr_en(wr_en), .wr_data(wr_data), .wr_sof(wr_sof),
        .o_h_disp(o_h_disp), .o_v_disp(o_v_disp), .input_done(input_done),
        .fifo_left_s(fifo_left_s), .err_pulse(err_pulse)
    );

    // Same stream with VS inverted into an active-low-sync instance.
    rgb_rx_capture #(.BURST_LEN_LOG2(5), .SYNC_ACT_HIGH(1'b0), .PAD_COLOR(PAD_COLOR)) dut_lo (
        .lcd_pclk(lcd_pclk), .rst_n(rst_n), .rx_de(rx_de), .rx_hs(rx_hs), .rx_vs(rx_vs_n),
        .rx_rgb(rx_rgb), .wr_en(lo_unused_wr_en), .wr_data(lo_unused_wr_data),
        .wr_sof(lo_unused_wr_sof), .o_h_disp(lo_h_disp), .o_v_disp(lo_v_disp),
        .input_done(lo_input_done), .fifo_left_s(lo_fifo_left_s), .err_pulse(lo_err_pulse)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int cyc = 0;
    always @(posedge lcd_pclk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   sof_cnt = 0;
    int   exp_sof = 0;
    pix_t exp_q[$];

    // Frame-level reference model: 0 idle, 1 measure, 2 verify, 3 locked.
    int mst = 0;
    int cand_h = 0, cand_v = 0;
    int lk_h = 0, lk_v = 0, lk_res = 0;
    bit done = 1'b0;
    bit wr_frame = 1'b0;
    bit prev_ok = 1'b0;
    int prev_h = 0, prev_v = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic de, input logic vs, input logic [15:0] rgb);
        rx_de  = de;
        rx_hs  = ~de;
        rx_vs  = vs;
        rx_rgb = rgb;
        @(posedge lcd_pclk);
        #1;
    endtask

    task automatic model_reset();
        mst = 0; cand_h = 0; cand_v = 0;
        lk_h = 0; lk_v = 0; lk_res = 0;
        done = 1'b0; wr_frame = 1'b0;
    endtask

    // Applies one frame boundary to the model (judging the previous frame) and checks the outputs.
    task automatic model_fb(output int npad);
        bit err;
        bit same;
        err  = 1'b0;
        npad = 0;
        wr_frame = 1'b0;
        same = prev_ok && prev_h == cand_h && prev_v == cand_v;
        case (mst)
            0: mst = 1;
            1: if (prev_ok) begin cand_h = prev_h; cand_v = prev_v; mst = 2; end
               else err = 1'b1;
            2: if (same) begin
                   lk_h = prev_h; lk_v = prev_v;
                   lk_res = (BURST - (prev_h * prev_v) % BURST) % BURST;
                   done = 1'b1; mst = 3;
               end else if (prev_ok) begin cand_h = prev_h; cand_v = prev_v; end
               else begin err = 1'b1; mst = 1; end
            default: if (same) begin
                   wr_frame = 1'b1;
                   exp_sof++;
`ifdef RX_BURST_PAD_EN
                   npad = lk_res;
`endif
               end else begin
                   err = 1'b1; done = 1'b0;
                   if (prev_ok) begin cand_h = prev_h; cand_v = prev_v; mst = 2; end
                   else mst = 1;
               end
        endcase
        check("input_done", input_done, done);
        check("o_h_disp", o_h_disp, lk_h);
        check("o_v_disp", o_v_disp, lk_v);
        check("fifo_left_s", fifo_left_s, lk_res);
        check("err_pulse", err_pulse, err);
        check("lo_input_done", lo_input_done, done);
        check("lo_h_disp", lo_h_disp, lk_h);
        check("lo_v_disp", lo_v_disp, lk_v);
        check("lo_fifo_left_s", lo_fifo_left_s, lk_res);
        check("lo_err_pulse", lo_err_pulse, err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_input_done"}, input_done, 0);
        check({tag, "_h_disp"}, o_h_disp, 0);
        check({tag, "_v_disp"}, o_v_disp, 0);
        check({tag, "_fifo_left_s"}, fifo_left_s, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_sof"}, wr_sof, 0);
        check({tag, "_err_pulse"}, err_pulse, 0);
        check({tag, "_lo_input_done"}, lo_input_done, 0);
    endtask

    // One frame: VS pulse (FB), porch, v lines of h pixels; line bad_idx has bad_len
    // pixels instead; reset is pulsed just before line rst_idx.
    task automatic send_frame(input int h, input int v, input int bad_idx, input int bad_len,
                              input int rst_idx);
        int   k, npad, len, maxlen;
        bit   ok, rst_hit;
        pix_t e;
        k = cyc;
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, '0);
        model_fb(npad);
        for (int i = 0; i < npad; i++) begin
            e.cyc = k + i; e.data = PAD_COLOR;
            exp_q.push_back(e);
        end
        drive(1'b0, 1'b1, '0);
        repeat ($urandom_range(40, 48)) drive(1'b0, 1'b0, '0);
        ok = (v > 0); maxlen = 0; rst_hit = 1'b0;
        for (int l = 0; l < v; l++) begin
            len = (l == bad_idx) ? bad_len : h;
            if (len != h) ok = 1'b0;
            if (len > maxlen) maxlen = len;
            if (l == rst_idx) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_rst");
                exp_q.delete();
                model_reset();
                rst_hit = 1'b1;
                @(posedge lcd_pclk);
                #1;
                rst_n = 1'b1;
            end
            for (int p = 0; p < len; p++) begin
                e.cyc  = cyc;
                e.data = 16'($urandom);
                if (wr_frame) exp_q.push_back(e);
                drive(1'b1, 1'b0, e.data);
            end
            repeat ($urandom_range(2, 5)) drive(1'b0, 1'b0, '0);
        end
        repeat (3) drive(1'b0, 1'b0, '0);
        check("sof_count", sof_cnt, exp_sof);
        prev_ok = ok && !rst_hit && maxlen >= 1 && maxlen <= 2047 && v <= 2047;
        prev_h  = h;
        prev_v  = v;
    endtask

    // Write-stream scoreboard: data and 2-cycle pin-to-write latency.
    initial begin
        pix_t e;
        forever begin
            @(posedge lcd_pclk);
            #2;
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", wr_en, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data", wr_data, e.data);
                    check("wr_latency", cyc, e.cyc + 2);
                end
            end
            if (wr_sof === 1'b1) sof_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, v;
        #3;
        check_reset_outputs("por");
        repeat (3) @(posedge lcd_pclk);
        #1;
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, '0);

        repeat (5) send_frame(16, 4, -1, 0, -1);  // lock, then written frames
        repeat (3) send_frame(15, 3, -1, 0, -1);  // lock loss, relock with residue 19
        repeat (3) send_frame(16, 4, -1, 0, -1);
        repeat (4) send_frame(17, 4, -1, 0, -1);  // one-frame change drops lock, two relock
        send_frame(16, 4, 2, 15, -1);            // short third line
        repeat (3) send_frame(17, 4, -1, 0, -1);
        send_frame(2100, 1, -1, 0, -1);          // saturated line
        repeat (2) send_frame(17, 4, -1, 0, -1);

        for (int n = 0; n < 3; n++) begin
            h = $urandom_range(1, 40);
            v = $urandom_range(1, 6);
            repeat (4) send_frame(h, v, -1, 0, -1);
        end

        repeat (2) send_frame(20, 5, -1, 0, -1);
        send_frame(20, 5, -1, 0, 2);             // reset mid-frame while locked
        repeat (4) send_frame(20, 5, -1, 0, -1);

        repeat (4) drive(1'b0, 1'b0, '0);
        check("wr_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
